bht_update_sched: RTL and testbench
===================================

// Module: bht_update_sched
// PURPOSE
//  Buffers branch-outcome updates retired by the ROB and issues them to the BHT update port, at most one per cycle.
//  Decouples ROB commit bursts from the single BHT update port.
//  Holds issue whenever the BHT would ignore an update (~rdy or Clear_flag), so no committed update is ever lost.
//  Sits between the ROB commit stage and BHT (bht_id2 / ROB_to_BHT_needchange* inputs).
// PARAMETERS
//  DEPTH   4  queue entries; power of two, >=2
//  IDX_W   8  BHT index width; must equal width of `BHT_LR_WIDTH
//  CNT_W   3  occupancy width = log2(DEPTH)+1
// PORTS
//  clk                     in   1      clock, all state updates on posedge
//  rst                     in   1      synchronous, active-high reset
//  rdy                     in   1      global ready; low = freeze all state
//  Clear_flag              in   1      pipeline flush; stalls issue only, queue kept
//  rob_upd_valid           in   1      ROB presents one retired-branch update
//  rob_upd_idx             in   IDX_W  BHT index of that branch
//  rob_upd_wrong           in   1      1 = mispredicted, 0 = predicted correctly
//  rob_upd_ready           out  1      queue accepts update this cycle
//  ROB_to_BHT_needchange   out  1      issue: mispredict update for bht_id2
//  ROB_to_BHT_needchange2  out  1      issue: correct-predict update for bht_id2
//  bht_id2                 out  IDX_W  BHT index being updated
//  upd_count               out  CNT_W  current occupancy
//  upd_pending_hit         out  1      see CONFIGURATION
//  bht_id1                 in   IDX_W  current BHT lookup index (hazard compare)
// BEHAVIOUR
//  - State: circular FIFO entry[DEPTH] = {idx, wrong}; head/tail ptrs log2(DEPTH) bits, wrap mod DEPTH; count 0..DEPTH.
//  - Reset: head=tail=0, count=0, entries cleared.
//    Combinational results in reset: rob_upd_ready=1 once rst is low and rdy=1; both issue strobes 0; bht_id2=0.
//  - rob_upd_ready = rdy && (count < DEPTH).
//    Full blocks enqueue even in a cycle where a dequeue also happens (no pass-through).
//  - enq = rob_upd_valid && rob_upd_ready.
//    At posedge: entry[tail] <= {idx, wrong}; tail++.
//  - issue = rdy && !Clear_flag && (count != 0).
//  - Issue strobes are combinational from the head entry:
//    - ROB_to_BHT_needchange  = issue && entry[head].wrong
//    - ROB_to_BHT_needchange2 = issue && !entry[head].wrong
//    - Exactly one strobe is high when issue=1; never both.
//  - bht_id2 = entry[head].idx when count!=0, else 0.
//  - On posedge with issue: head++ (pop). The BHT applies the update at the same edge.
//  - Latency: an update enqueued at edge N into an empty queue is issued in cycle N..N+1 and applied at edge N+1.
//    No same-cycle bypass.
//  - Simultaneous enq+issue: count unchanged; both pointers advance.
//  - Order: strict FIFO; updates to the same index are applied in retire order and never merged.
//  - rdy=0: no enq, no pop, strobes 0, all state held.
//  - Clear_flag=1 (rdy=1): strobes 0, no pop; enqueue still allowed (ROB commits are architectural).
//  - rst asserted mid-operation: queue discarded next edge; rst takes priority over rdy.
// CONFIGURATION
//  - BHT_SCHED_HAZARD_EN defined:
//    upd_pending_hit = OR over valid entries (including head) of (entry.idx == bht_id1).
//    Lets the front end know its prediction reads a counter with pending updates.
//  - Undefined: upd_pending_hit tied 0; comparators are not built.
// TESTING
//  1. rst 1 cycle, then idle
//     -> count=0, rob_upd_ready=1, both strobes 0, bht_id2=0.
//  2. enq {idx=5, wrong=1} at edge N
//     -> cycle after N: needchange=1, bht_id2=5; count=0 after edge N+1.
//  3. DEPTH=4: 5 back-to-back valids with Clear_flag=1 throughout
//     -> 4 accepted, ready=0 on the 5th, count=4.
//     Then drop Clear_flag -> issues idx in order, 1/cycle, 4 cycles.
//  4. count=2, rdy=0 for 3 cycles
//     -> strobes 0, count stays 2, ready=0; resumes correctly when rdy=1.
//  5. count=1 with enq and issue in the same cycle
//     -> count stays 1; pointers wrap past DEPTH-1 to 0 without corruption.
//  6. HAZARD_EN: queue {3,7}, bht_id1=7 -> upd_pending_hit=1; bht_id1=4 -> 0.
//     Without macro: always 0.

Source files
------------

// File: rtl/bht_update_sched.sv
// Retired-branch update queue feeding the single BHT update port.
// Optional: BHT_SCHED_HAZARD_EN builds the bht_id1 pending-update compare.
module bht_update_sched #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             Clear_flag,
  input  logic             rob_upd_valid,
  input  logic [IDX_W-1:0] rob_upd_idx,
  input  logic             rob_upd_wrong,
  output logic             rob_upd_ready,
  output logic             ROB_to_BHT_needchange,
  output logic             ROB_to_BHT_needchange2,
  output logic [IDX_W-1:0] bht_id2,
  output logic [CNT_W-1:0] upd_count,
  output logic             upd_pending_hit,
  input  logic [IDX_W-1:0] bht_id1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wrong;
  } ent_t;

  ent_t             ent_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic enq;
  logic issue;
  logic nonempty;
  ent_t head_e;

  assign nonempty = (cnt_q != '0);
  assign head_e   = ent_q[head_q];

  assign rob_upd_ready = rdy && (cnt_q < FULL);
  assign enq   = rob_upd_valid && rob_upd_ready;
  assign issue = rdy && !Clear_flag && nonempty;

  assign ROB_to_BHT_needchange  = issue && head_e.wrong;
  assign ROB_to_BHT_needchange2 = issue && !head_e.wrong;
  assign bht_id2   = nonempty ? head_e.idx : '0;
  assign upd_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      if (enq) begin
        ent_q[tail_q] <= '{idx: rob_upd_idx,
                           wrong: rob_upd_wrong};
        tail_q <= tail_q + PTR_W'(1);
      end
      if (issue)
        head_q <= head_q + PTR_W'(1);
      unique case (1'b1)
        enq && !issue: cnt_q <= cnt_q + CNT_W'(1);
        issue && !enq: cnt_q <= cnt_q - CNT_W'(1);
        default:       cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef BHT_SCHED_HAZARD_EN
  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    upd_pending_hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if ((CNT_W'(off) < cnt_q) &&
          (ent_q[i].idx == bht_id1))
        upd_pending_hit = 1'b1;
    end
  end
`else
  logic unused_id1;
  assign unused_id1 = ^bht_id1;
  assign upd_pending_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Scoreboard bench for bht_update_sched: directed cases then random traffic.
// Model is a plain queue of pending {idx, wrong} updates.
module tb_bht_update_sched;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b0;
  logic             Clear_flag = 1'b0;
  logic             rob_upd_valid = 1'b0;
  logic [IDX_W-1:0] rob_upd_idx = '0;
  logic             rob_upd_wrong = 1'b0;
  logic             rob_upd_ready;
  logic             ROB_to_BHT_needchange;
  logic             ROB_to_BHT_needchange2;
  logic [IDX_W-1:0] bht_id2;
  logic [CNT_W-1:0] upd_count;
  logic             upd_pending_hit;
  logic [IDX_W-1:0] bht_id1 = '0;

  bht_update_sched #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .Clear_flag(Clear_flag),
    .rob_upd_valid(rob_upd_valid),
    .rob_upd_idx(rob_upd_idx),
    .rob_upd_wrong(rob_upd_wrong),
    .rob_upd_ready(rob_upd_ready),
    .ROB_to_BHT_needchange(ROB_to_BHT_needchange),
    .ROB_to_BHT_needchange2(ROB_to_BHT_needchange2),
    .bht_id2(bht_id2),
    .upd_count(upd_count),
    .upd_pending_hit(upd_pending_hit),
    .bht_id1(bht_id1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             wrong;
  } upd_t;

  upd_t sb [$];
  upd_t pend_e;
  bit   pend = 1'b0;
  bit   last_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; the model is advanced
  // at the edge so its contents match the DUT's registered state.
  task automatic step(input bit r, input bit rd, input bit c,
                      input bit v, input int i, input bit w,
                      input int id1);
    @(posedge clk);
    if (last_rst) sb.delete();
    else if (pend) sb.push_back(pend_e);
    pend = 1'b0;
    #1;
    rst = r;
    rdy = rd;
    Clear_flag = c;
    rob_upd_valid = v;
    rob_upd_idx = IDX_W'(i);
    rob_upd_wrong = w;
    bht_id1 = IDX_W'(id1);
    last_rst = r;
    if (!r && rd && v && sb.size() < DEPTH) begin
      pend = 1'b1;
      pend_e.idx = IDX_W'(i);
      pend_e.wrong = w;
    end
  endtask

  // Monitor: compares every output against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin : mon
        bit   exp_iss;
        bit   exp_hit;
        upd_t e;
        exp_iss = rdy && !Clear_flag && sb.size() != 0;
        chk("upd_count", 32'(upd_count), 32'(sb.size()));
        chk("rob_upd_ready", 32'(rob_upd_ready),
            32'(rdy && sb.size() < DEPTH));
        exp_hit = 1'b0;
`ifdef BHT_SCHED_HAZARD_EN
        foreach (sb[k])
          if (sb[k].idx == bht_id1) exp_hit = 1'b1;
`endif
        chk("upd_pending_hit", 32'(upd_pending_hit),
            32'(exp_hit));
        if (sb.size() == 0) begin
          chk("bht_id2_empty", 32'(bht_id2), 32'd0);
        end else begin
          chk("bht_id2", 32'(bht_id2), 32'(sb[0].idx));
        end
        if (exp_iss) begin
          e = sb.pop_front();
          chk("needchange", 32'(ROB_to_BHT_needchange),
              32'(e.wrong));
          chk("needchange2", 32'(ROB_to_BHT_needchange2),
              32'(!e.wrong));
        end else begin
          chk("needchange_idle", 32'(ROB_to_BHT_needchange),
              32'd0);
          chk("needchange2_idle",
              32'(ROB_to_BHT_needchange2), 32'd0);
        end
      end
    end
  end

  initial begin
    // reset then idle
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // single mispredict update, then idle
    step(0, 1, 0, 1, 5, 1, 0);
    step(0, 1, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0, 0, 0, 5);
    // five valids under Clear_flag, then drain
    for (int k = 0; k < 5; k++)
      step(0, 1, 1, 1, 10 + k, k[0], 12);
    for (int k = 0; k < 5; k++)
      step(0, 1, 0, 0, 0, 0, 11);
    // two queued, rdy low three cycles
    step(0, 1, 1, 1, 21, 0, 0);
    step(0, 1, 1, 1, 22, 1, 0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 1, 99, 1, 22);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // steady count=1 with enq+issue each cycle, wraps pointers
    step(0, 1, 0, 1, 30, 0, 0);
    for (int k = 0; k < 7; k++)
      step(0, 1, 0, 1, 31 + k, k[0], 33);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // hazard compare on queue {3,7}
    step(0, 1, 1, 1, 3, 0, 0);
    step(0, 1, 1, 1, 7, 1, 0);
    step(0, 1, 1, 0, 0, 0, 7);
    step(0, 1, 1, 0, 0, 0, 4);
    step(0, 1, 1, 0, 0, 0, 3);
    // reset mid-operation discards queue
    step(1, 0, 0, 1, 9, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, rd, c, v, w;
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 2) != 0);
      w  = 1'($urandom);
      step(r, rd, c, v, $urandom_range(0, 7), w,
           $urandom_range(0, 7));
    end
    step(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
